// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state type and step-counter sizing for serial_subtractor.
package serial_sub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int MAX_STEPS = 64;
    localparam int CNT_W = $clog2(MAX_STEPS);
endpackage

// File: rtl/sub_slice.sv
// sub_slice: combinational DIGIT-bit ripple-borrow subtract slice (d = x - y - bi).
module sub_slice import serial_sub_pkg::*; #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);
    logic [DIGIT:0] br;
    assign br[0] = bi;
    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign d[i]    = x[i] ^ y[i] ^ br[i];
        assign br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
    end
    assign bo = br[DIGIT];
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial A - B - BIN with valid/ready handshake and held result flags.
module serial_subtractor import serial_sub_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);
    localparam int N = WIDTH / DIGIT;
    if (DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_subtractor: DIGIT must divide WIDTH");
    end
    if (N > MAX_STEPS) begin : g_bad_steps
        $error("serial_subtractor: too many digit steps");
    end
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr, b_sr, res_nx;
    logic [DIGIT-1:0] d_dig;
    logic borrow, bo_dig, a_msb, b_msb, accept, last;
    sub_slice #(.DIGIT(DIGIT)) u_slice (
        .x (a_sr[DIGIT-1:0]),
        .y (b_sr[DIGIT-1:0]),
        .bi(borrow),
        .d (d_dig),
        .bo(bo_dig)
    );
    // result digits enter from the top so the LSB digit ends at bit 0 after N steps
    assign res_nx    = (diff >> DIGIT) | (WIDTH'(d_dig) << (WIDTH - DIGIT));
    assign in_ready  = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
    assign out_valid = state == DONE;
    assign accept    = in_valid & in_ready;
    assign last      = (state == RUN) && (cnt == CNT_W'(N - 1));
    always_comb begin
        state_nx = state;
        if (accept) state_nx = RUN;
        else if (last) state_nx = DONE;
        else if (state == DONE && out_ready) state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            borrow <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_sr   <= a;
                b_sr   <= b;
                borrow <= bin;
                a_msb  <= a[WIDTH-1];
                b_msb  <= b[WIDTH-1];
                cnt    <= '0;
            end else if (state == RUN) begin
                a_sr   <= a_sr >> DIGIT;
                b_sr   <= b_sr >> DIGIT;
                borrow <= bo_dig;
                diff   <= res_nx;
                cnt    <= cnt + CNT_W'(1);
                if (last) begin
                    bout <= bo_dig;
                    ovf  <= (a_msb ^ b_msb) & (res_nx[WIDTH-1] ^ a_msb);
                    zero <= ~|res_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of serial_subtractor in four WIDTH/DIGIT configurations.
module tb_serial_subtractor;
    localparam int WS [4] = '{16, 16, 16, 32};
    localparam int DS [4] = '{4, 1, 16, 8};
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] in_valid_s, in_ready_s, bin_s, out_valid_s, out_ready_s, bout_s, ovf_s, zero_s;
    logic [31:0] a_s [4];
    logic [31:0] b_s [4];
    logic [31:0] diff_s [4];
    int n_tests = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = WS[g];
        logic [W-1:0] d;
        serial_subtractor #(.WIDTH(W), .DIGIT(DS[g])) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid_s[g]),
            .in_ready (in_ready_s[g]),
            .a        (a_s[g][W-1:0]),
            .b        (b_s[g][W-1:0]),
            .bin      (bin_s[g]),
            .out_valid(out_valid_s[g]),
            .out_ready(out_ready_s[g]),
            .diff     (d),
            .bout     (bout_s[g]),
            .ovf      (ovf_s[g]),
            .zero     (zero_s[g])
        );
        assign diff_s[g] = 32'(d);
    end
    task automatic check(string tag, longint unsigned got, longint unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // reference: plain integer arithmetic, signed overflow from the true signed range
    function automatic void golden(int w, longint unsigned av, longint unsigned bv, logic bi,
                                   output longint unsigned d, output logic bo, output logic ov, output logic z);
        longint unsigned m = (64'd1 << w) - 1;
        longint sa, sb, r;
        d  = (av - bv - longint'(bi)) & m;
        bo = av < bv + longint'(bi);
        sa = av[w-1] ? longint'(av) - longint'(64'd1 << w) : longint'(av);
        sb = bv[w-1] ? longint'(bv) - longint'(64'd1 << w) : longint'(bv);
        r  = sa - sb - longint'(bi);
        ov = (r < -(longint'(1) << (w - 1))) || (r > (longint'(1) << (w - 1)) - 1);
        z  = d == 0;
    endfunction
    task automatic send(int k, longint unsigned av, longint unsigned bv, logic bi);
        int t = 0;
        a_s[k] = 32'(av);
        b_s[k] = 32'(bv);
        bin_s[k] = bi;
        in_valid_s[k] = 1'b1;
        while (!in_ready_s[k] && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) check("accept_wait", in_ready_s[k], 1);
        @(posedge clk); #1;
        in_valid_s[k] = 1'b0;
        a_s[k] = $urandom;
        b_s[k] = $urandom;
        bin_s[k] = 1'($urandom);
    endtask
    task automatic expect_result(int k, string tag, longint unsigned av, longint unsigned bv, logic bi);
        longint unsigned d;
        logic bo, ov, z;
        int lat = 0;
        golden(WS[k], av, bv, bi, d, bo, ov, z);
        while (!out_valid_s[k] && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, WS[k] / DS[k]);
        check({tag, "_diff"}, diff_s[k], d);
        check({tag, "_bout"}, bout_s[k], bo);
        check({tag, "_ovf"}, ovf_s[k], ov);
        check({tag, "_zero"}, zero_s[k], z);
    endtask
    task automatic retire(int k, string tag);
        out_ready_s[k] = 1'b1;
        @(posedge clk); #1;
        out_ready_s[k] = 1'b0;
        check({tag, "_retired"}, out_valid_s[k], 0);
    endtask
    task automatic run_op(int k, string tag, longint unsigned av, longint unsigned bv, logic bi);
        send(k, av, bv, bi);
        expect_result(k, tag, av, bv, bi);
        retire(k, tag);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end
    initial begin
        in_valid_s = '0;
        out_ready_s = '0;
        bin_s = '0;
        for (int i = 0; i < 4; i++) begin
            a_s[i] = '0;
            b_s[i] = '0;
        end
        #2;
        check("rst_in_ready", in_ready_s[0], 0);
        check("rst_out_valid", out_valid_s[0], 0);
        check("rst_diff", diff_s[0], 0);
        check("rst_flags", {bout_s[0], ovf_s[0], zero_s[0]}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 check("rel_in_ready", in_ready_s[0], 1);
        run_op(0, "basic", 'h1234, 'h0234, 0);
        run_op(0, "wrap", 'h0000, 'h0001, 0);
        run_op(0, "equal", 'h0005, 'h0005, 0);
        run_op(0, "ovf", 'h8000, 'h0001, 0);
        run_op(0, "bin", 'h0005, 'h0005, 1);
        send(0, 'h00F0, 'h0F00, 0);
        expect_result(0, "bp", 'h00F0, 'h0F00, 0);
        a_s[0] = 'h7000;
        b_s[0] = 'h9000;
        bin_s[0] = 1'b1;
        in_valid_s[0] = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_hold_diff", diff_s[0], 'hF1F0);
            check("bp_hold_valid", out_valid_s[0], 1);
            check("bp_hold_ready", in_ready_s[0], 0);
        end
        out_ready_s[0] = 1'b1;
        #1 check("bp_ready_follows", in_ready_s[0], 1);
        @(posedge clk); #1;
        in_valid_s[0] = 1'b0;
        out_ready_s[0] = 1'b0;
        a_s[0] = 'h1111;
        expect_result(0, "overlap", 'h7000, 'h9000, 1);
        retire(0, "overlap");
        send(0, 'hFFFF, 'h1111, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_diff", diff_s[0], 0);
        check("mid_rst_flags", {out_valid_s[0], bout_s[0], ovf_s[0], zero_s[0]}, 0);
        check("mid_rst_in_ready", in_ready_s[0], 0);
        @(negedge clk) rst_n = 1'b1;
        begin
            logic seen = 1'b0;
            repeat (10) begin
                @(posedge clk); #1;
                seen |= out_valid_s[0];
            end
            check("mid_rst_no_valid", seen, 0);
        end
        check("mid_rst_ready", in_ready_s[0], 1);
        run_op(0, "after_rst", 'h0100, 'h0001, 0);
        for (int k = 1; k < 4; k++) begin
            longint unsigned m = (64'd1 << WS[k]) - 1;
            for (int i = 0; i < 30; i++) begin
                longint unsigned av = {$urandom, $urandom} & m;
                longint unsigned bv = ($urandom_range(0, 4) == 0) ? av : ({$urandom, $urandom} & m);
                run_op(k, $sformatf("rnd%0d", k), av, bv, 1'($urandom));
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
